rx_msg_reg: RTL and testbench

Receive-side message register for the wireless hangman link. It collects bytes strobed out of the UART receiver into a fixed-length message and presents the completed message to the game logic. The message is held stable until the game logic acknowledges it. It is the counterpart of the transmit-side `msg_reg`, which serialises messages out through `tx_ctrl`/`tx_byte`. It also drives a status LED and flags framing, timeout and overrun errors.

---
 rtl/rx_msg_reg.sv | 154 +++++++++++++++
 tb/tb_rx_msg_reg.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_msg_reg.sv
// Receive-side message register: assembles UART bytes into a MSG_LEN-byte message held until acked.
// Optional feature macro: RX_MSG_ASCII_FILTER_EN (accept letters only, fold lowercase to uppercase).
module rx_msg_reg #(
    parameter int MSG_LEN = 5,
    parameter int TIMEOUT = 100
) (
    input  logic                 clk,
    input  logic                 nRst,
    input  logic                 rx_ready,
    input  logic [7:0]           rx_byte,
    input  logic                 rx_err,
    input  logic                 msg_ack,
    output logic [8*MSG_LEN-1:0] msg,
    output logic                 msg_valid,
    output logic                 busy,
    output logic                 err,
    output logic                 green,
    output logic [1:0]           dbg_state
);

    localparam int CW = $clog2(MSG_LEN + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RECEIVE = 2'd1,
        S_DONE    = 2'd2
    } state_t;

    state_t               r_state, w_state_nxt;
    logic [CW-1:0]        r_cnt, w_cnt_nxt, w_idx;
    logic [TW-1:0]        r_timer, w_timer_nxt;
    logic [8*MSG_LEN-1:0] r_buf, r_msg, w_buf_wr;
    logic                 r_msg_valid, r_busy, r_err;
    logic                 w_err_evt, w_accept, w_complete, w_byte_ok;
    logic [7:0]           w_byte_st;

`ifdef RX_MSG_ASCII_FILTER_EN
    logic w_upper, w_lower;
    assign w_upper   = (rx_byte >= 8'h41) && (rx_byte <= 8'h5A);
    assign w_lower   = (rx_byte >= 8'h61) && (rx_byte <= 8'h7A);
    assign w_byte_ok = w_upper || w_lower;
    assign w_byte_st = w_lower ? (rx_byte - 8'h20) : rx_byte;
`else
    assign w_byte_ok = 1'b1;
    assign w_byte_st = rx_byte;
`endif

    // Shadow buffer with the incoming byte merged in; msg is loaded from this only on completion.
    assign w_idx = (r_state == S_RECEIVE) ? r_cnt : '0;
    always_comb begin
        w_buf_wr = r_buf;
        for (int i = 0; i < MSG_LEN; i++) begin
            if (w_idx == CW'(i)) w_buf_wr[8*(MSG_LEN-1-i) +: 8] = w_byte_st;
        end
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_timer_nxt = r_timer;
        w_err_evt   = 1'b0;
        w_accept    = 1'b0;
        w_complete  = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_cnt_nxt   = '0;
                w_timer_nxt = '0;
                if (rx_err || (rx_ready && !w_byte_ok)) begin
                    w_err_evt = 1'b1;
                end else if (rx_ready) begin
                    w_accept = 1'b1;
                    if (MSG_LEN == 1) begin
                        w_complete  = 1'b1;
                        w_state_nxt = S_DONE;
                    end else begin
                        w_cnt_nxt   = CW'(1);
                        w_state_nxt = S_RECEIVE;
                    end
                end
            end
            S_RECEIVE: begin
                if (rx_err || (rx_ready && !w_byte_ok)) begin
                    w_err_evt   = 1'b1;
                    w_cnt_nxt   = '0;
                    w_timer_nxt = '0;
                    w_state_nxt = S_IDLE;
                end else if (rx_ready) begin
                    // A strobe in the expiry cycle wins over the timeout.
                    w_accept    = 1'b1;
                    w_timer_nxt = '0;
                    if (r_cnt == CW'(MSG_LEN - 1)) begin
                        w_complete  = 1'b1;
                        w_cnt_nxt   = '0;
                        w_state_nxt = S_DONE;
                    end else begin
                        w_cnt_nxt = r_cnt + CW'(1);
                    end
                end else if (r_timer == TW'(TIMEOUT - 1)) begin
                    w_err_evt   = 1'b1;
                    w_cnt_nxt   = '0;
                    w_timer_nxt = '0;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_timer_nxt = r_timer + TW'(1);
                end
            end
            S_DONE: begin
                // Handshake: msg_valid stays high with msg frozen until the edge sampling msg_ack;
                // any byte arriving meanwhile (even alongside the ack) is an overrun and is dropped.
                if (rx_ready || rx_err) w_err_evt = 1'b1;
                if (msg_ack) w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
                w_timer_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            r_cnt       <= '0;
            r_timer     <= '0;
            r_buf       <= '0;
            r_msg       <= '0;
            r_msg_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_cnt       <= w_cnt_nxt;
            r_timer     <= w_timer_nxt;
            if (w_accept)   r_buf <= w_buf_wr;
            if (w_complete) r_msg <= w_buf_wr;
            r_msg_valid <= (w_state_nxt == S_DONE);
            r_busy      <= (w_state_nxt == S_RECEIVE);
            r_err       <= w_err_evt;
        end
    end

    assign msg       = r_msg;
    assign msg_valid = r_msg_valid;
    assign green     = r_msg_valid;
    assign busy      = r_busy;
    assign err       = r_err;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_rx_msg_reg.sv
// Directed self-checking bench for rx_msg_reg (MSG_LEN=5, TIMEOUT=100).
// Exercises the RX_MSG_ASCII_FILTER_EN path when that macro is defined, verbatim storage otherwise.
module tb_rx_msg_reg;

    logic        clk;
    logic        nRst;
    logic        rx_ready;
    logic [7:0]  rx_byte;
    logic        rx_err;
    logic        msg_ack;
    logic [39:0] msg;
    logic        msg_valid;
    logic        busy;
    logic        err;
    logic        green;
    logic [1:0]  dbg_state;

    int n_checks;
    int n_fail;

    rx_msg_reg #(.MSG_LEN(5), .TIMEOUT(100)) dut (
        .clk       (clk),
        .nRst      (nRst),
        .rx_ready  (rx_ready),
        .rx_byte   (rx_byte),
        .rx_err    (rx_err),
        .msg_ack   (msg_ack),
        .msg       (msg),
        .msg_valid (msg_valid),
        .busy      (busy),
        .err       (err),
        .green     (green),
        .dbg_state (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] b, input logic e);
        rx_ready = 1'b1;
        rx_byte  = b;
        rx_err   = e;
        tick(1);
        rx_ready = 1'b0;
        rx_byte  = 8'h00;
        rx_err   = 1'b0;
    endtask

    task automatic send_msg(input logic [39:0] m, input int gap);
        for (int i = 0; i < 5; i++) begin
            send(m[39-8*i -: 8], 1'b0);
            if (i < 4) tick(gap);
        end
    endtask

    task automatic ack();
        msg_ack = 1'b1;
        tick(1);
        msg_ack = 1'b0;
    endtask

    task automatic test_reset();
        nRst = 1'b0;
        rx_ready = 1'b0; rx_byte = 8'h00; rx_err = 1'b0; msg_ack = 1'b0;
        #22;
        n_checks++;
        if (msg !== 40'h0 || msg_valid !== 1'b0 || busy !== 1'b0 || err !== 1'b0 || green !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got msg=%h valid=%b busy=%b err=%b green=%b required all 0",
                     msg, msg_valid, busy, err, green);
        end
        nRst = 1'b1;
        tick(1);
    endtask

    task automatic test_framing();
        send(8'h41, 1'b0); send(8'h42, 1'b0); send(8'h43, 1'b0);
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL framing_busy: got %b required 1", busy); end
        send(8'h44, 1'b1);
        n_checks++;
        if (err !== 1'b1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL framing_err: got err=%b busy=%b required err=1 busy=0", err, busy);
        end
        n_checks++;
        if (msg !== 40'h0 || msg_valid !== 1'b0) begin
            n_fail++; $display("FAIL framing_msg: got msg=%h valid=%b required 0/0", msg, msg_valid);
        end
        tick(1);
        n_checks++;
        if (err !== 1'b0) begin n_fail++; $display("FAIL framing_pulse_len: got err=%b required 0", err); end
    endtask

    task automatic test_back_to_back_err();
        rx_err = 1'b1;
        tick(1);
        n_checks++;
        if (err !== 1'b1) begin n_fail++; $display("FAIL idle_err_first: got %b required 1", err); end
        rx_ready = 1'b1; rx_byte = 8'h41;
        tick(1);
        rx_ready = 1'b0; rx_err = 1'b0;
        n_checks++;
        if (err !== 1'b1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL idle_err_second: got err=%b busy=%b required err=1 busy=0", err, busy);
        end
        tick(1);
        n_checks++;
        if (err !== 1'b0) begin n_fail++; $display("FAIL idle_err_end: got %b required 0", err); end
    endtask

    task automatic test_basic();
        send(8'h48, 1'b0); tick(2);
        send(8'h45, 1'b0); tick(2);
        send(8'h4C, 1'b0); tick(2);
        send(8'h4C, 1'b0);
        n_checks++;
        if (busy !== 1'b1 || msg !== 40'h0 || msg_valid !== 1'b0) begin
            n_fail++; $display("FAIL basic_partial: got busy=%b msg=%h valid=%b required 1/0/0", busy, msg, msg_valid);
        end
        tick(2);
        send(8'h4F, 1'b0);
        n_checks++;
        if (msg !== 40'h48454C4C4F) begin
            n_fail++; $display("FAIL basic_msg: got %h required 48454c4c4f", msg);
        end
        n_checks++;
        if (msg_valid !== 1'b1 || green !== 1'b1 || busy !== 1'b0 || err !== 1'b0) begin
            n_fail++; $display("FAIL basic_flags: got valid=%b green=%b busy=%b err=%b required 1/1/0/0",
                               msg_valid, green, busy, err);
        end
        tick(3);
        n_checks++;
        if (msg_valid !== 1'b1) begin n_fail++; $display("FAIL basic_hold: got %b required 1", msg_valid); end
        ack();
        n_checks++;
        if (msg_valid !== 1'b0 || green !== 1'b0) begin
            n_fail++; $display("FAIL basic_ack: got valid=%b green=%b required 0/0", msg_valid, green);
        end
    endtask

    task automatic test_overrun();
        send_msg(40'h48454C4C4F, 0);
        n_checks++;
        if (msg !== 40'h48454C4C4F || msg_valid !== 1'b1) begin
            n_fail++; $display("FAIL overrun_b2b_msg: got msg=%h valid=%b required 48454c4c4f/1", msg, msg_valid);
        end
        send(8'h41, 1'b0);
        n_checks++;
        if (err !== 1'b1 || msg !== 40'h48454C4C4F || msg_valid !== 1'b1) begin
            n_fail++; $display("FAIL overrun_byte: got err=%b msg=%h valid=%b required 1/48454c4c4f/1", err, msg, msg_valid);
        end
        rx_err = 1'b1;
        tick(1);
        rx_err = 1'b0;
        n_checks++;
        if (err !== 1'b1 || msg !== 40'h48454C4C4F || msg_valid !== 1'b1) begin
            n_fail++; $display("FAIL done_rx_err: got err=%b msg=%h valid=%b required 1/48454c4c4f/1", err, msg, msg_valid);
        end
        msg_ack = 1'b1;
        send(8'h42, 1'b0);
        msg_ack = 1'b0;
        n_checks++;
        if (err !== 1'b1 || msg_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL overrun_ack: got err=%b valid=%b busy=%b required 1/0/0", err, msg_valid, busy);
        end
        tick(1);
        n_checks++;
        if (err !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL overrun_dropped: got err=%b busy=%b required 0/0", err, busy);
        end
    endtask

    task automatic test_timeout();
        int k;
        send(8'h57, 1'b0); send(8'h4F, 1'b0);
        k = 0;
        for (int i = 1; i <= 200; i++) begin
            tick(1);
            if (err === 1'b1) begin k = i; break; end
        end
        n_checks++;
        if (k != 100) begin n_fail++; $display("FAIL timeout_cycles: got %0d required 100", k); end
        n_checks++;
        if (busy !== 1'b0 || msg_valid !== 1'b0) begin
            n_fail++; $display("FAIL timeout_state: got busy=%b valid=%b required 0/0", busy, msg_valid);
        end
        tick(1);
        n_checks++;
        if (err !== 1'b0) begin n_fail++; $display("FAIL timeout_pulse_len: got %b required 0", err); end
        send(8'h57, 1'b0);
        tick(99);
        n_checks++;
        if (err !== 1'b0 || busy !== 1'b1) begin
            n_fail++; $display("FAIL timeout_edge_wait: got err=%b busy=%b required 0/1", err, busy);
        end
        send(8'h4F, 1'b0);
        n_checks++;
        if (err !== 1'b0 || busy !== 1'b1) begin
            n_fail++; $display("FAIL timeout_strobe_wins: got err=%b busy=%b required 0/1", err, busy);
        end
        msg_ack = 1'b1;
        send(8'h52, 1'b0);
        msg_ack = 1'b0;
        send(8'h44, 1'b0); send(8'h53, 1'b0);
        n_checks++;
        if (msg !== 40'h574F524453 || msg_valid !== 1'b1 || err !== 1'b0) begin
            n_fail++; $display("FAIL words_msg: got msg=%h valid=%b err=%b required 574f524453/1/0", msg, msg_valid, err);
        end
        ack();
    endtask

    task automatic test_reset_mid();
        send(8'h52, 1'b0); send(8'h45, 1'b0); send(8'h53, 1'b0); send(8'h45, 1'b0);
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL mid_busy: got %b required 1", busy); end
        nRst = 1'b0;
        #1;
        n_checks++;
        if (msg !== 40'h0 || msg_valid !== 1'b0 || busy !== 1'b0 || err !== 1'b0 || green !== 1'b0) begin
            n_fail++; $display("FAIL mid_reset_async: got msg=%h valid=%b busy=%b err=%b green=%b required all 0",
                               msg, msg_valid, busy, err, green);
        end
        #2;
        nRst = 1'b1;
        tick(1);
        send_msg(40'h4652455348, 1);
        n_checks++;
        if (msg !== 40'h4652455348 || msg_valid !== 1'b1) begin
            n_fail++; $display("FAIL mid_fresh_msg: got msg=%h valid=%b required 4652455348/1", msg, msg_valid);
        end
        ack();
    endtask

    task automatic test_data_path();
`ifdef RX_MSG_ASCII_FILTER_EN
        send_msg(40'h68656C6C6F, 1);
        n_checks++;
        if (msg !== 40'h48454C4C4F || msg_valid !== 1'b1) begin
            n_fail++; $display("FAIL filter_lower: got msg=%h valid=%b required 48454c4c4f/1", msg, msg_valid);
        end
        ack();
        send(8'h48, 1'b0); send(8'h45, 1'b0); send(8'h31, 1'b0);
        n_checks++;
        if (err !== 1'b1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL filter_digit: got err=%b busy=%b required 1/0", err, busy);
        end
        send(8'h4C, 1'b0); send(8'h4F, 1'b0);
        n_checks++;
        if (msg_valid !== 1'b0 || busy !== 1'b1) begin
            n_fail++; $display("FAIL filter_no_valid: got valid=%b busy=%b required 0/1", msg_valid, busy);
        end
`else
        send_msg(40'h00FF31617F, 0);
        n_checks++;
        if (msg !== 40'h00FF31617F || msg_valid !== 1'b1 || err !== 1'b0) begin
            n_fail++; $display("FAIL verbatim_msg: got msg=%h valid=%b err=%b required 00ff31617f/1/0", msg, msg_valid, err);
        end
        ack();
`endif
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_framing();
        test_back_to_back_err();
        test_basic();
        test_overrun();
        test_timeout();
        test_reset_mid();
        test_data_path();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
